// File: rtl/sub_stage.sv
// Pipelined CHANNELS x WIDTH lane combiner (AND/OR/XOR/ADD) with valid/ready flow control.
// Optional 1-entry output skid register enabled by defining SUB_STAGE_SKID_EN.
module sub_stage #(
  parameter int WIDTH    = 8,
  parameter int CHANNELS = 4,
  parameter int DEPTH    = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                op,
  input  logic [CHANNELS*WIDTH-1:0] a,
  input  logic [CHANNELS*WIDTH-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [CHANNELS*WIDTH-1:0] c,
  output logic [15:0]               xfer_cnt
);

  localparam int DW = CHANNELS * WIDTH;

  // Handshake: a beat moves on a port in any cycle where its valid and ready
  // are both 1 at the rising edge; valid never waits on ready.

  logic [DW-1:0]    w_f;
  logic             w_adv;
  logic             w_pipe_vld;
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_vld;
  logic [15:0]      r_cnt;

  // ADD keeps each lane's sum to WIDTH bits, so no carry crosses lanes.
  always_comb begin
    w_f = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      case (op)
        2'd0:    w_f[k*WIDTH +: WIDTH] = a[k*WIDTH +: WIDTH] & b[k*WIDTH +: WIDTH];
        2'd1:    w_f[k*WIDTH +: WIDTH] = a[k*WIDTH +: WIDTH] | b[k*WIDTH +: WIDTH];
        2'd2:    w_f[k*WIDTH +: WIDTH] = a[k*WIDTH +: WIDTH] ^ b[k*WIDTH +: WIDTH];
        default: w_f[k*WIDTH +: WIDTH] = a[k*WIDTH +: WIDTH] + b[k*WIDTH +: WIDTH];
      endcase
    end
  end

  assign w_pipe_vld = r_vld[DEPTH-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= '0;
      for (int i = 0; i < DEPTH; i++) r_data[i] <= '0;
    end else if (w_adv) begin
      r_vld[0]  <= in_valid;
      r_data[0] <= w_f;
      for (int i = 1; i < DEPTH; i++) begin
        r_vld[i]  <= r_vld[i-1];
        r_data[i] <= r_data[i-1];
      end
    end
  end

`ifdef SUB_STAGE_SKID_EN
  // r_in_rdy is the "skid empty" flag; while it is set the pipe runs freely
  // and an unaccepted last-stage beat drops into the skid register.
  logic          r_in_rdy;
  logic [DW-1:0] r_skid_dat;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_in_rdy   <= 1'b1;
      r_skid_dat <= '0;
    end else if (r_in_rdy) begin
      if (w_pipe_vld && !out_ready) begin
        r_in_rdy   <= 1'b0;
        r_skid_dat <= r_data[DEPTH-1];
      end
    end else if (out_ready) begin
      r_in_rdy <= 1'b1;
    end
  end

  assign w_adv     = r_in_rdy;
  assign in_ready  = r_in_rdy;
  assign out_valid = r_in_rdy ? w_pipe_vld : 1'b1;
  assign c         = r_in_rdy ? r_data[DEPTH-1] : r_skid_dat;
`else
  assign w_adv     = !w_pipe_vld || out_ready;
  assign in_ready  = w_adv;
  assign out_valid = w_pipe_vld;
  assign c         = r_data[DEPTH-1];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (out_valid && out_ready) begin
      r_cnt <= r_cnt + 16'd1;
    end
  end

  assign xfer_cnt = r_cnt;

endmodule

// File: tb/tb_sub_stage.sv
// Self-checking bench for sub_stage: vector table, scoreboard queue, stall/reset/wrap sequences,
// plus a second WIDTH=1/CHANNELS=1/DEPTH=1 instance.
`timescale 1ns/1ps
module tb_sub_stage;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid, in_ready, out_valid, out_ready;
  logic [1:0]    op;
  logic [DW-1:0] a, b, c;
  logic [15:0]   xfer_cnt;

  logic          in1_valid, in1_ready, out1_valid, out1_ready;
  logic [1:0]    op1;
  logic [0:0]    a1, b1, c1;
  logic [15:0]   xfer1;

  int            errors = 0;
  int            checks = 0;
  logic [DW-1:0] exp_q[$];
  logic [15:0]   exp_cnt;
  logic [DW-1:0] drv_exp;
  logic          mon_en;
  logic          hold_prev;
  logic [DW-1:0] prev_c;

  typedef struct {
    logic [1:0]    op;
    logic [DW-1:0] a;
    logic [DW-1:0] b;
    logic [DW-1:0] exp;
  } vec_t;
  vec_t tbl[10];

  always #5 clk = ~clk;

  sub_stage #(.WIDTH(8), .CHANNELS(4), .DEPTH(2)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready), .c(c), .xfer_cnt(xfer_cnt)
  );

  sub_stage #(.WIDTH(1), .CHANNELS(1), .DEPTH(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in1_valid), .in_ready(in1_ready), .op(op1),
    .a(a1), .b(b1), .out_valid(out1_valid), .out_ready(out1_ready), .c(c1), .xfer_cnt(xfer1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] model(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y);
    logic [DW-1:0] r;
    logic [7:0]    p, q;
    r = '0;
    for (int k = 0; k < 4; k++) begin
      p = x[k*8 +: 8];
      q = y[k*8 +: 8];
      case (o)
        2'd0:    r[k*8 +: 8] = p & q;
        2'd1:    r[k*8 +: 8] = p | q;
        2'd2:    r[k*8 +: 8] = p ^ q;
        default: r[k*8 +: 8] = p + q;
      endcase
    end
    return r;
  endfunction

  // Scoreboard: push on input handshake, pop/compare on output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("xfer_cnt", 32'(xfer_cnt), 32'(exp_cnt));
        if (rst) begin
          exp_q.delete();
          exp_cnt   = '0;
          hold_prev = 1'b0;
        end else begin
          if (hold_prev) begin
            chk("stall_valid", 32'(out_valid), 32'd1);
            chk("stall_c", c, prev_c);
          end
          if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_out: got %h expected no beat", c);
            end else begin
              chk("c", c, exp_q.pop_front());
            end
            exp_cnt++;
          end
          hold_prev = out_valid && !out_ready;
          prev_c    = c;
          if (in_valid && in_ready) exp_q.push_back(drv_exp);
        end
      end
    end
  end

  task automatic send_beat(input logic [1:0] o, input logic [DW-1:0] x, input logic [DW-1:0] y,
                           input logic [DW-1:0] e);
    int n;
    @(posedge clk); #1;
    in_valid = 1'b1; op = o; a = x; b = y; drv_exp = e;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout: got in_ready=0 expected 1 within 50 cycles");
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    idle(1);
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 32'(exp_q.size()), 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    time t0, t1;
    int  nb;
    logic [DW-1:0] ra, rb;
    logic [1:0]    ro;

    tbl[0] = '{2'd0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505};
    tbl[1] = '{2'd1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAFAFAFAF};
    tbl[2] = '{2'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA};
    tbl[3] = '{2'd3, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hB4B4B4B4};
    tbl[4] = '{2'd0, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'h05050505};
    tbl[5] = '{2'd1, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAFAFAFAF};
    tbl[6] = '{2'd2, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hAAAAAAAA};
    tbl[7] = '{2'd3, 32'hA5A5A5A5, 32'h0F0F0F0F, 32'hB4B4B4B4};
    tbl[8] = '{2'd3, 32'h01FF7FFF, 32'h01010101, 32'h02008000};
    tbl[9] = '{2'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFEFEFEFE};

    rst = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b1; drv_exp = '0;
    in1_valid = 1'b0; op1 = '0; a1 = '0; b1 = '0; out1_ready = 1'b1;
    mon_en = 1'b0; exp_cnt = '0; hold_prev = 1'b0; prev_c = '0;

    // Clock/reset
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_xfer_cnt", 32'(xfer_cnt), 32'd0);
    chk("rst_c", c, 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst1_out_valid", 32'(out1_valid), 32'd0);
    mon_en = 1'b1;

    // Single ADD beat with lane wrap and latency check
    @(posedge clk); #1;
    in_valid = 1'b1; op = 2'd3; a = 32'h000000F0; b = 32'h00000020; drv_exp = 32'h00000010;
    @(negedge clk);
    chk("t1_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("t1_lat_early", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("t1_lat_valid", 32'(out_valid), 32'd1);
    chk("t1_c", c, 32'h00000010);
    repeat (2) @(negedge clk);
    chk("t1_cnt", 32'(xfer_cnt), 32'd1);

    // Table vectors back-to-back, one per cycle
    t0 = $time;
    for (int i = 0; i < 10; i++) send_beat(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].exp);
    t1 = $time;
    chk("throughput", 32'((t1 - t0) / 10), 32'd10);
    drain();

    // Random vectors with random input gaps
    for (int i = 0; i < 16; i++) begin
      ra = $urandom; rb = $urandom; ro = 2'($urandom_range(0, 3));
      send_beat(ro, ra, rb, model(ro, ra, rb));
      idle($urandom_range(0, 2));
    end
    drain();

    // Mid-stream stall of 5 cycles
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          ra = $urandom; rb = $urandom; ro = 2'($urandom_range(0, 3));
          send_beat(ro, ra, rb, model(ro, ra, rb));
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        chk("stall_out_valid", 32'(out_valid), 32'd1);
`ifdef SUB_STAGE_SKID_EN
        chk("stall_in_ready_t0", 32'(in_ready), 32'd1);
`else
        chk("stall_in_ready_t0", 32'(in_ready), 32'd0);
`endif
        @(negedge clk);
        chk("stall_in_ready_t1", 32'(in_ready), 32'd0);
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Reset with two beats in flight
    send_beat(2'd1, 32'h11111111, 32'h22222222, 32'h33333333);
    send_beat(2'd2, 32'h44444444, 32'h00000000, 32'h44444444);
    @(posedge clk); #1;
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_cnt", 32'(xfer_cnt), 32'd0);
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    idle(6);

    // Narrow instance: OR then ADD wrap, DEPTH=1
    @(posedge clk); #1;
    in1_valid = 1'b1; op1 = 2'd1; a1 = 1'b1; b1 = 1'b0;
    @(negedge clk);
    chk("w1_in_ready", 32'(in1_ready), 32'd1);
    @(posedge clk); #1;
    op1 = 2'd3; a1 = 1'b1; b1 = 1'b1;
    @(negedge clk);
    chk("w1_or_valid", 32'(out1_valid), 32'd1);
    chk("w1_or_c", 32'(c1), 32'd1);
    @(posedge clk); #1;
    in1_valid = 1'b0;
    @(negedge clk);
    chk("w1_add_valid", 32'(out1_valid), 32'd1);
    chk("w1_add_c", 32'(c1), 32'd0);
    @(negedge clk);
    chk("w1_idle_valid", 32'(out1_valid), 32'd0);
    chk("w1_cnt", 32'(xfer1), 32'd2);

    // Counter wrap: fill to 0xFFFF, then one more transfer
    nb = 65535 - int'(exp_cnt);
    for (int i = 0; i < nb; i++) send_beat(2'd2, 32'h12345678, 32'hFFFFFFFF, 32'hEDCBA987);
    drain();
    chk("cnt_ffff", 32'(xfer_cnt), 32'h0000FFFF);
    send_beat(2'd0, 32'hFFFFFFFF, 32'h3C3C3C3C, 32'h3C3C3C3C);
    drain();
    chk("cnt_wrap", 32'(xfer_cnt), 32'h00000000);

    chk("leftover", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
